// File: rtl/writeback_pkg.sv
// Shared types and default widths for the register-file writeback arbiter.
package writeback_pkg;

    localparam int DATABITWIDTH_DEF    = 16;
    localparam int REGADDRBITWIDTH_DEF = 4;
    localparam int SOURCECOUNT_DEF     = 4;
    localparam int BUFFERDEPTH_DEF     = 2;

    localparam int SRCIDXBITWIDTH = $clog2(SOURCECOUNT_DEF);

    typedef struct packed {
        logic [REGADDRBITWIDTH_DEF-1:0] RegAddr;
        logic [DATABITWIDTH_DEF-1:0]    Data;
    } wb_entry_t;

endpackage

// File: rtl/writeback_fifo.sv
// Per-source result FIFO; push and pop may coincide, gated by clk_en, sync reset.
module writeback_fifo #(
    parameter int ENTRYBITWIDTH = 20,
    parameter int DEPTH         = 2
) (
    input  logic                     clk,
    input  logic                     clk_en,
    input  logic                     sync_rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [ENTRYBITWIDTH-1:0] pushEntry,
    output logic [ENTRYBITWIDTH-1:0] headEntry,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = PTRW + 1;

    logic [ENTRYBITWIDTH-1:0] mem [DEPTH];
    logic [PTRW-1:0]          wrPtr;
    logic [PTRW-1:0]          rdPtr;
    logic                     doPush;
    logic                     doPop;

    assign empty     = (count == '0);
    assign full      = (count == CNTW'(DEPTH));
    assign headEntry = mem[rdPtr];
    assign doPush    = push && !full;
    assign doPop     = pop && !empty;

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (clk_en) begin
            if (doPush) begin
                mem[wrPtr] <= pushEntry;
                wrPtr      <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Round-robin arbiter sharing the register-file write port among buffered result sources.
module writeback_arbiter
    import writeback_pkg::*;
#(
    parameter int DATABITWIDTH    = DATABITWIDTH_DEF,
    parameter int REGADDRBITWIDTH = REGADDRBITWIDTH_DEF,
    parameter int SOURCECOUNT     = SOURCECOUNT_DEF,
    parameter int BUFFERDEPTH     = BUFFERDEPTH_DEF
) (
    input  logic                                   clk,
    input  logic                                   clk_en,
    input  logic                                   sync_rst,
    input  logic [SOURCECOUNT-1:0]                 Src_Valid,
    output logic [SOURCECOUNT-1:0]                 Src_Ready,
    input  logic [SOURCECOUNT*REGADDRBITWIDTH-1:0] Src_RegAddr,
    input  logic [SOURCECOUNT*DATABITWIDTH-1:0]    Src_Data,
    output logic                                   Write_En,
    output logic [REGADDRBITWIDTH-1:0]             Write_Address,
    output logic [DATABITWIDTH-1:0]                Write_Data,
    output logic [$clog2(SOURCECOUNT)-1:0]         Write_Source,
    output logic                                   CongestionStall
);

    localparam int SRCW = $clog2(SOURCECOUNT);
    localparam int ENTW = REGADDRBITWIDTH + DATABITWIDTH;
    localparam int CNTW = $clog2(BUFFERDEPTH) + 1;

    logic [SOURCECOUNT-1:0] srcPush;
    logic [SOURCECOUNT-1:0] srcPop;
    logic [SOURCECOUNT-1:0] srcEmpty;
    logic [SOURCECOUNT-1:0] srcFull;
    logic [ENTW-1:0]        headEntry [SOURCECOUNT];
    logic [CNTW-1:0]        srcCount  [SOURCECOUNT];
    logic [SRCW-1:0]        rrPtr;
    logic [SRCW-1:0]        winner;
    logic [SRCW-1:0]        rrNext;
    logic                   anyPending;

    // First requester at or after ptr, wrapping modulo SOURCECOUNT.
    function automatic logic [SRCW-1:0] rrPick(input logic [SOURCECOUNT-1:0] req,
                                               input logic [SRCW-1:0]        ptr);
        int   idx;
        logic found;
        rrPick = ptr;
        found  = 1'b0;
        for (int k = 0; k < SOURCECOUNT; k++) begin
            idx = (int'(ptr) + k) % SOURCECOUNT;
            if (!found && req[idx]) begin
                rrPick = idx[SRCW-1:0];
                found  = 1'b1;
            end
        end
    endfunction

    assign anyPending      = ~&srcEmpty;
    assign winner          = rrPick(~srcEmpty, rrPtr);
    assign rrNext          = (winner == SRCW'(SOURCECOUNT - 1)) ? '0 : winner + 1'b1;
    assign CongestionStall = |srcFull;

    for (genvar i = 0; i < SOURCECOUNT; i++) begin : g_src
        assign Src_Ready[i] = (srcCount[i] != CNTW'(BUFFERDEPTH));
        assign srcPush[i]   = Src_Valid[i] && Src_Ready[i];
        assign srcPop[i]    = anyPending && (winner == SRCW'(i));

        writeback_fifo #(
            .ENTRYBITWIDTH(ENTW),
            .DEPTH        (BUFFERDEPTH)
        ) u_fifo (
            .clk      (clk),
            .clk_en   (clk_en),
            .sync_rst (sync_rst),
            .push     (srcPush[i]),
            .pop      (srcPop[i]),
            .pushEntry({Src_RegAddr[i*REGADDRBITWIDTH +: REGADDRBITWIDTH],
                        Src_Data[i*DATABITWIDTH +: DATABITWIDTH]}),
            .headEntry(headEntry[i]),
            .count    (srcCount[i]),
            .empty    (srcEmpty[i]),
            .full     (srcFull[i])
        );
    end

    // Address/data/source hold through idle cycles; only the strobe drops.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            Write_En      <= 1'b0;
            Write_Address <= '0;
            Write_Data    <= '0;
            Write_Source  <= '0;
            rrPtr         <= '0;
        end else if (clk_en) begin
            if (anyPending) begin
                Write_En                    <= 1'b1;
                {Write_Address, Write_Data} <= headEntry[winner];
                Write_Source                <= winner;
                rrPtr                       <= rrNext;
            end else begin
                Write_En <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed vector table, corner sequences, random run vs queue model.
module tb_writeback_arbiter;
    import writeback_pkg::*;

    localparam int N     = 4;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        clk_en;
    logic        sync_rst;
    logic [3:0]  Src_Valid;
    logic [3:0]  Src_Ready;
    logic [15:0] Src_RegAddr;
    logic [63:0] Src_Data;
    logic        Write_En;
    logic [3:0]  Write_Address;
    logic [15:0] Write_Data;
    logic [1:0]  Write_Source;
    logic        CongestionStall;

    int vecCount  = 0;
    int missCount = 0;

    always #5 clk = ~clk;

    writeback_arbiter #(
        .DATABITWIDTH(16), .REGADDRBITWIDTH(4), .SOURCECOUNT(N), .BUFFERDEPTH(DEPTH)
    ) dut (
        .clk            (clk),
        .clk_en         (clk_en),
        .sync_rst       (sync_rst),
        .Src_Valid      (Src_Valid),
        .Src_Ready      (Src_Ready),
        .Src_RegAddr    (Src_RegAddr),
        .Src_Data       (Src_Data),
        .Write_En       (Write_En),
        .Write_Address  (Write_Address),
        .Write_Data     (Write_Data),
        .Write_Source   (Write_Source),
        .CongestionStall(CongestionStall)
    );

    // Reference model: one queue per source plus the write-port image.
    wb_entry_t   mq [N][$];
    int          mPtr;
    logic        mWe;
    logic [3:0]  mAddr;
    logic [15:0] mData;
    logic [1:0]  mSrc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelEdge(input logic rst, input logic en, input logic [3:0] v,
                             input logic [15:0] a, input logic [63:0] d);
        int        w;
        bit        rdy [N];
        wb_entry_t e;
        if (rst) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            mPtr = 0; mWe = 1'b0; mAddr = '0; mData = '0; mSrc = '0;
        end else if (en) begin
            w = -1;
            for (int i = 0; i < N; i++) rdy[i] = (mq[i].size() < DEPTH);
            for (int k = 0; k < N; k++)
                if (w < 0 && mq[(mPtr + k) % N].size() > 0) w = (mPtr + k) % N;
            if (w >= 0) begin
                e     = mq[w].pop_front();
                mWe   = 1'b1;
                mAddr = e.RegAddr;
                mData = e.Data;
                mSrc  = 2'(w);
                mPtr  = (w + 1) % N;
            end else begin
                mWe = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (v[i] && rdy[i]) begin
                    e.RegAddr = a[i*4 +: 4];
                    e.Data    = d[i*16 +: 16];
                    mq[i].push_back(e);
                end
            end
        end
    endtask

    task automatic checkModel();
        logic [3:0] expReady;
        logic       expStall;
        expStall = 1'b0;
        for (int i = 0; i < N; i++) begin
            expReady[i] = (mq[i].size() != DEPTH);
            if (mq[i].size() == DEPTH) expStall = 1'b1;
        end
        chk("m_we", 64'(Write_En), 64'(mWe));
        chk("m_addr", 64'(Write_Address), 64'(mAddr));
        chk("m_data", 64'(Write_Data), 64'(mData));
        chk("m_src", 64'(Write_Source), 64'(mSrc));
        chk("m_ready", 64'(Src_Ready), 64'(expReady));
        chk("m_stall", 64'(CongestionStall), 64'(expStall));
    endtask

    task automatic cycle(input logic rst, input logic en, input logic [3:0] v,
                         input logic [15:0] a, input logic [63:0] d);
        sync_rst = rst; clk_en = en; Src_Valid = v; Src_RegAddr = a; Src_Data = d;
        modelEdge(rst, en, v, a, d);
        @(posedge clk);
        #1;
        checkModel();
    endtask

    typedef struct {
        logic        rst;
        logic        en;
        logic [3:0]  valid;
        logic [15:0] addrs;
        logic [63:0] datas;
        logic        we;
        logic [3:0]  addr;
        logic [15:0] data;
        logic [1:0]  src;
        logic [3:0]  ready;
        logic        stall;
    } vec_t;

    vec_t tbl [12];
    int   fairExp [4];

    initial begin
        sync_rst = 1'b1; clk_en = 1'b1; Src_Valid = '0; Src_RegAddr = '0; Src_Data = '0;

        // Reset, single source, round-robin over all four sources.
        tbl[0]  = '{1'b1, 1'b1, 4'hF, 16'h0000, 64'h0, 1'b0, 4'h0, 16'h0000, 2'd0, 4'hF, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 4'hF, 16'h0000, 64'h0, 1'b0, 4'h0, 16'h0000, 2'd0, 4'hF, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 4'h4, 16'h0500, 64'h0000_1234_0000_0000, 1'b0, 4'h0, 16'h0000, 2'd0, 4'hF, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 4'h0, 16'h0000, 64'h0, 1'b1, 4'h5, 16'h1234, 2'd2, 4'hF, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 4'h0, 16'h0000, 64'h0, 1'b0, 4'h5, 16'h1234, 2'd2, 4'hF, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 4'h0, 16'h0000, 64'h0, 1'b0, 4'h0, 16'h0000, 2'd0, 4'hF, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 4'hF, 16'h4321, 64'hA003_A002_A001_A000, 1'b0, 4'h0, 16'h0000, 2'd0, 4'hF, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 4'h0, 16'h0000, 64'h0, 1'b1, 4'h1, 16'hA000, 2'd0, 4'hF, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 4'h0, 16'h0000, 64'h0, 1'b1, 4'h2, 16'hA001, 2'd1, 4'hF, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 4'h0, 16'h0000, 64'h0, 1'b1, 4'h3, 16'hA002, 2'd2, 4'hF, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 4'h0, 16'h0000, 64'h0, 1'b1, 4'h4, 16'hA003, 2'd3, 4'hF, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 4'h0, 16'h0000, 64'h0, 1'b0, 4'h4, 16'hA003, 2'd3, 4'hF, 1'b0};

        for (int r = 0; r < 12; r++) begin
            cycle(tbl[r].rst, tbl[r].en, tbl[r].valid, tbl[r].addrs, tbl[r].datas);
            chk($sformatf("t%0d_we", r), 64'(Write_En), 64'(tbl[r].we));
            chk($sformatf("t%0d_addr", r), 64'(Write_Address), 64'(tbl[r].addr));
            chk($sformatf("t%0d_data", r), 64'(Write_Data), 64'(tbl[r].data));
            chk($sformatf("t%0d_src", r), 64'(Write_Source), 64'(tbl[r].src));
            chk($sformatf("t%0d_ready", r), 64'(Src_Ready), 64'(tbl[r].ready));
            chk($sformatf("t%0d_stall", r), 64'(CongestionStall), 64'(tbl[r].stall));
        end

        // Fairness wrap: move RRPtr to 3, then keep sources 0 and 3 valid.
        fairExp = '{3, 0, 3, 0};
        cycle(1'b1, 1'b1, 4'h0, 16'h0, 64'h0);
        cycle(1'b0, 1'b1, 4'h4, 16'h9707, 64'h0903_0007_0000_0800);
        cycle(1'b0, 1'b1, 4'h9, 16'h9708, 64'h0903_0007_0000_0800);
        chk("fair_pre_src", 64'(Write_Source), 64'd2);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b1, 4'h9, 16'h9708, 64'h0903_0007_0000_0800);
            chk($sformatf("fair%0d_src", k), 64'(Write_Source), 64'(fairExp[k]));
            chk($sformatf("fair%0d_we", k), 64'(Write_En), 64'd1);
        end
        for (int k = 0; k < 6; k++) cycle(1'b0, 1'b1, 4'h0, 16'h0, 64'h0);

        // Congestion: sources 0/2/3 hold entries while source 1 fills up.
        cycle(1'b1, 1'b1, 4'h0, 16'h0, 64'h0);
        cycle(1'b0, 1'b1, 4'hD, 16'h4321, 64'h3333_2222_1111_0000);
        cycle(1'b0, 1'b1, 4'hD, 16'h4321, 64'h3333_2222_1111_0000);
        cycle(1'b0, 1'b1, 4'h2, 16'h4321, 64'h3333_2222_1111_0000);
        chk("cong1_stall", 64'(CongestionStall), 64'd1);
        cycle(1'b0, 1'b1, 4'h2, 16'h4321, 64'h3333_2222_1111_0000);
        chk("cong2_ready1", 64'(Src_Ready[1]), 64'd0);
        chk("cong2_stall", 64'(CongestionStall), 64'd1);
        cycle(1'b0, 1'b1, 4'h2, 16'h4321, 64'h3333_2222_1111_0000);
        chk("cong3_ready1", 64'(Src_Ready[1]), 64'd0);
        cycle(1'b0, 1'b1, 4'h2, 16'h4321, 64'h3333_2222_1111_0000);
        chk("cong4_src", 64'(Write_Source), 64'd1);
        chk("cong4_ready1", 64'(Src_Ready[1]), 64'd1);
        for (int k = 0; k < 8; k++) cycle(1'b0, 1'b1, 4'h0, 16'h0, 64'h0);

        // clk_en freeze, then reset with two entries still queued.
        cycle(1'b1, 1'b1, 4'h0, 16'h0, 64'h0);
        cycle(1'b0, 1'b1, 4'h3, 16'h4321, 64'h4444_3333_2222_1111);
        cycle(1'b0, 1'b1, 4'h0, 16'h0, 64'h0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, 4'hF, 16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF);
            chk("frz_we", 64'(Write_En), 64'd1);
            chk("frz_addr", 64'(Write_Address), 64'd1);
            chk("frz_data", 64'(Write_Data), 64'h1111);
        end
        cycle(1'b0, 1'b1, 4'hC, 16'h4321, 64'h4444_3333_2222_1111);
        chk("unfrz_src", 64'(Write_Source), 64'd1);
        cycle(1'b1, 1'b1, 4'h0, 16'h0, 64'h0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b1, 4'h0, 16'h0, 64'h0);
            chk("mrst_we", 64'(Write_En), 64'd0);
            chk("mrst_ready", 64'(Src_Ready), 64'hF);
        end

        // Random traffic against the queue model.
        for (int k = 0; k < 500; k++) begin
            cycle(($urandom_range(99) < 2) ? 1'b1 : 1'b0,
                  ($urandom_range(99) < 85) ? 1'b1 : 1'b0,
                  4'($urandom),
                  16'($urandom),
                  {$urandom, $urandom});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
